// File: rtl/mem_arb_pkg.sv
// Shared constants and helpers for the two-bank SRAM arbiter.
//   DEF_ADDR_W / DEF_DATA_W : default SRAM word-address and data widths
//   BANK0 / BANK1           : bank select encodings carried on the bank inputs
//   idx_clog2()             : client-index width, never less than one bit
package mem_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 19;
    localparam int unsigned DEF_DATA_W = 36;

    localparam logic BANK0 = 1'b0;
    localparam logic BANK1 = 1'b1;

    // Bits needed to hold a client index 0..n-1 (a single client still gets one bit).
    function automatic int unsigned idx_clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(n)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mem_arb_bank.sv
// One SRAM bank's slice of the arbiter: candidate mask, winner picker,
// memory port mux and the read-tag pipeline that routes returning data.
// Build option: MEM_ARBITER_RR_EN selects round-robin instead of fixed priority.
//   clock, reset      : system clock, synchronous active-high reset
//   req_i/wr_i/bank_i : per-client request, direction (1=write), target bank
//   addr_i/wdata_i    : per-client address and write data, packed per client
//   grant_o           : combinational one-hot grant for this bank
//   mem_*             : SRAM port for this bank
//   rvalid_o/rdata_o  : per-client read return from this bank (data 0 when not valid)
module mem_arb_bank
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS = 4,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned READ_LAT    = 2,
    parameter logic        BANK_SEL    = BANK0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_CLIENTS-1:0]        req_i,
    input  logic [NUM_CLIENTS-1:0]        wr_i,
    input  logic [NUM_CLIENTS-1:0]        bank_i,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] addr_i,
    input  logic [NUM_CLIENTS*DATA_W-1:0] wdata_i,
    output logic [NUM_CLIENTS-1:0]        grant_o,
    output logic [ADDR_W-1:0]             mem_addr_o,
    output logic [DATA_W-1:0]             mem_write_o,
    output logic                          mem_wr_o,
    input  logic [DATA_W-1:0]             mem_read_i,
    output logic [NUM_CLIENTS-1:0]        rvalid_o,
    output logic [NUM_CLIENTS*DATA_W-1:0] rdata_o
);

    localparam int unsigned IDX_W = idx_clog2(NUM_CLIENTS);

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } tag_t;

    logic [NUM_CLIENTS-1:0] cand;
    logic                   win_any;
    logic [IDX_W-1:0]       win_idx;
    tag_t                   tag_d;
    tag_t                   tag_q [READ_LAT];
    tag_t                   tag_tail;

    // Clients asking for this bank; reset suppresses every request.
    always_comb begin
        cand = '0;
        for (int c = 0; c < int'(NUM_CLIENTS); c++) begin
            cand[c] = req_i[c] && (bank_i[c] == BANK_SEL) && !reset;
        end
    end

`ifdef MEM_ARBITER_RR_EN
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic             hi_any;
    logic [IDX_W-1:0] hi_idx;

    // Round-robin: prefer the lowest candidate above the last winner,
    // otherwise wrap to the lowest candidate overall.
    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        hi_any  = 1'b0;
        hi_idx  = '0;
        for (int c = int'(NUM_CLIENTS) - 1; c >= 0; c--) begin
            if (cand[c]) begin
                win_any = 1'b1;
                win_idx = IDX_W'(c);
                if (IDX_W'(c) > ptr_q) begin
                    hi_any = 1'b1;
                    hi_idx = IDX_W'(c);
                end
            end
        end
        if (hi_any) begin
            win_idx = hi_idx;
        end
    end

    // Last-winner pointer moves only when this bank grants.
    always_comb begin
        ptr_d = ptr_q;
        if (win_any) begin
            ptr_d = win_idx;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= IDX_W'(NUM_CLIENTS - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority: lowest-index candidate wins.
    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        for (int c = int'(NUM_CLIENTS) - 1; c >= 0; c--) begin
            if (cand[c]) begin
                win_any = 1'b1;
                win_idx = IDX_W'(c);
            end
        end
    end
`endif

    // Grant decode and SRAM port mux; an idle bank drives all zeros.
    always_comb begin
        grant_o     = '0;
        mem_addr_o  = '0;
        mem_write_o = '0;
        mem_wr_o    = 1'b0;
        for (int c = 0; c < int'(NUM_CLIENTS); c++) begin
            if (win_any && (win_idx == IDX_W'(c))) begin
                grant_o[c] = 1'b1;
                mem_addr_o = addr_i[c*ADDR_W +: ADDR_W];
                mem_wr_o   = wr_i[c];
                if (wr_i[c]) begin
                    mem_write_o = wdata_i[c*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Only granted reads enter the tag pipeline.
    always_comb begin
        tag_d       = '0;
        tag_d.valid = win_any && !mem_wr_o;
        tag_d.idx   = win_idx;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(READ_LAT); i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= tag_d;
            for (int i = 1; i < int'(READ_LAT); i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign tag_tail = tag_q[READ_LAT-1];

    // Route returning SRAM data to the issuing client; masked during reset so a
    // read issued just before reset can never surface.
    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        for (int c = 0; c < int'(NUM_CLIENTS); c++) begin
            if (!reset && tag_tail.valid && (tag_tail.idx == IDX_W'(c))) begin
                rvalid_o[c]                  = 1'b1;
                rdata_o[c*DATA_W +: DATA_W]  = mem_read_i;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// N-client arbiter for the two external SRAM banks (mem0/mem1). Each bank is
// arbitrated independently by a mem_arb_bank instance; grants and read returns
// of the two banks are merged here.
// Build option: MEM_ARBITER_RR_EN selects per-bank round-robin arbitration.
//   clock, reset           : system clock, synchronous active-high reset
//   req, wr, bank          : per-client request, direction (1=write), bank (0=mem0)
//   addr, wdata            : per-client address / write data, client c at [c*W +: W]
//   grant                  : combinational accept, one per client
//   rvalid, rdata          : per-client read return strobe and data
//   mem0_*, mem1_*         : SRAM bank ports
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS = 4,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned READ_LAT    = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_CLIENTS-1:0]        req,
    input  logic [NUM_CLIENTS-1:0]        wr,
    input  logic [NUM_CLIENTS-1:0]        bank,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] addr,
    input  logic [NUM_CLIENTS*DATA_W-1:0] wdata,
    output logic [NUM_CLIENTS-1:0]        grant,
    output logic [NUM_CLIENTS-1:0]        rvalid,
    output logic [NUM_CLIENTS*DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0]             mem0_addr,
    output logic [DATA_W-1:0]             mem0_write,
    output logic                          mem0_wr,
    input  logic [DATA_W-1:0]             mem0_read,
    output logic [ADDR_W-1:0]             mem1_addr,
    output logic [DATA_W-1:0]             mem1_write,
    output logic                          mem1_wr,
    input  logic [DATA_W-1:0]             mem1_read
);

    logic [NUM_CLIENTS-1:0]        grant0, grant1;
    logic [NUM_CLIENTS-1:0]        rvalid0, rvalid1;
    logic [NUM_CLIENTS*DATA_W-1:0] rdata0, rdata1;

    mem_arb_bank #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .READ_LAT    (READ_LAT),
        .BANK_SEL    (BANK0)
    ) u_bank0 (
        .clock       (clock),
        .reset       (reset),
        .req_i       (req),
        .wr_i        (wr),
        .bank_i      (bank),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .grant_o     (grant0),
        .mem_addr_o  (mem0_addr),
        .mem_write_o (mem0_write),
        .mem_wr_o    (mem0_wr),
        .mem_read_i  (mem0_read),
        .rvalid_o    (rvalid0),
        .rdata_o     (rdata0)
    );

    mem_arb_bank #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .READ_LAT    (READ_LAT),
        .BANK_SEL    (BANK1)
    ) u_bank1 (
        .clock       (clock),
        .reset       (reset),
        .req_i       (req),
        .wr_i        (wr),
        .bank_i      (bank),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .grant_o     (grant1),
        .mem_addr_o  (mem1_addr),
        .mem_write_o (mem1_write),
        .mem_wr_o    (mem1_wr),
        .mem_read_i  (mem1_read),
        .rvalid_o    (rvalid1),
        .rdata_o     (rdata1)
    );

    // A client targets one bank per request, so the banks never return to the
    // same client in one cycle and a plain OR merge is exact.
    assign grant  = grant0 | grant1;
    assign rvalid = rvalid0 | rvalid1;
    assign rdata  = rdata0 | rdata1;

endmodule
